srt_div_arbiter: RTL and testbench

SRT_DIV_ARBITER -- requirements
Module: srt_div_arbiter

---
 rtl/srt_div_pkg.sv | 18 +
 rtl/srt_div_arbiter_if.sv | 40 ++++
 rtl/SRTDivider.sv | 85 ++++++++
 rtl/rr_arbiter.sv | 32 +++
 rtl/srt_div_arbiter.sv | 120 ++++++++++++
 tb/tb_srt_div_arbiter.sv | 296 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/srt_div_pkg.sv
// Shared definitions for the shared-divider arbiter.
// Holds the controller state encoding and the default operand width and
// requester count used by the interface and the top level.
package srt_div_pkg;

    // Controller states: wait for a request, reset the divider, let it run,
    // then present the result until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEF_N    = 16;
    localparam int DEF_NREQ = 4;

endpackage

// File: rtl/srt_div_arbiter_if.sv
// Request/response bundle for srt_div_arbiter.
//   req_valid/req_ready : per-requester handshake (ready is one-hot)
//   req_signed          : per-requester signed-operation flag
//   req_x/req_y         : packed dividends/divisors, requester k at [k*N +: N]
//   resp_valid/ready    : result handshake
//   resp_id             : requester that owns the result
//   resp_q/resp_r       : quotient / remainder
//   resp_dbz            : divide-by-zero flag
// master = requesters + consumer side, slave = arbiter side.
interface srt_div_arbiter_if
    import srt_div_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int NREQ = DEF_NREQ
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_signed;
    logic [NREQ*N-1:0] req_x;
    logic [NREQ*N-1:0] req_y;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [N-1:0]      resp_q;
    logic [N-1:0]      resp_r;
    logic              resp_dbz;

    modport master (
        output req_valid, req_signed, req_x, req_y, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_q, resp_r, resp_dbz
    );

    modport slave (
        input  req_valid, req_signed, req_x, req_y, resp_ready,
        output req_ready, resp_valid, resp_id, resp_q, resp_r, resp_dbz
    );

endinterface

// File: rtl/SRTDivider.sv
// Iterative N-bit divider with optional signed operands.
//   clk, rst            : clock, synchronous reset (clears done)
//   start               : hold high to launch; sampled once when idle
//   x, y, signedInput   : dividend, divisor, signed mode
//   done                : high from completion until the next rst
//   q, r                : quotient, remainder magnitude
//   divByZeroEx         : divisor was zero
// Works on magnitudes: one load cycle then N shift/subtract steps, so done
// rises N+1 cycles after start is first seen. The quotient is truncated
// toward zero and re-signed; the remainder is returned as |x| mod |y|.
// rst is treated synchronously so a decoded state bit can drive it safely.
module SRTDivider #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         signedInput,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         divByZeroEx
);
    localparam int CW = $clog2(N + 1);

    logic          busy_reg, done_reg, neg_q_reg, dbz_reg;
    logic [CW-1:0] cnt_reg;
    logic [N-1:0]  rem_reg, quo_reg, den_reg, q_reg, r_reg;

    logic          x_neg, y_neg;
    logic [N-1:0]  x_mag, y_mag;
    logic [N:0]    rem_shift, trial;
    logic [N-1:0]  quo_shift;

    assign x_neg = signedInput & x[N-1];
    assign y_neg = signedInput & y[N-1];
    assign x_mag = x_neg ? -x : x;
    assign y_mag = y_neg ? -y : y;

    // restoring step: shift in next dividend bit, try subtracting divisor
    assign rem_shift = {rem_reg, quo_reg[N-1]};
    assign trial     = rem_shift - {1'b0, den_reg};
    assign quo_shift = {quo_reg[N-2:0], ~trial[N]};

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            neg_q_reg <= 1'b0;
            dbz_reg   <= 1'b0;
            cnt_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            den_reg   <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
        end else if (start && !busy_reg && !done_reg) begin
            busy_reg  <= 1'b1;
            cnt_reg   <= CW'(N);
            rem_reg   <= '0;
            quo_reg   <= x_mag;
            den_reg   <= y_mag;
            neg_q_reg <= x_neg ^ y_neg;
            dbz_reg   <= (y == '0);
        end else if (busy_reg) begin
            rem_reg <= trial[N] ? rem_shift[N-1:0] : trial[N-1:0];
            quo_reg <= quo_shift;
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == CW'(1)) begin
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
                q_reg    <= neg_q_reg ? -quo_shift : quo_shift;
                r_reg    <= trial[N] ? rem_shift[N-1:0] : trial[N-1:0];
            end
        end
    end

    assign done        = done_reg;
    assign q           = q_reg;
    assign r           = r_reg;
    assign divByZeroEx = dbz_reg;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant generator.
//   req   : request vector
//   last  : index of the most recently granted requester
//   grant : one-hot grant (all zero when nothing requests)
// Search starts at last+1 and wraps, so the last winner has lowest priority.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant
);

    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = last;
        for (int i = 0; i < NREQ; i++) begin
            // step to the next index with explicit wrap (NREQ need not be 2^k)
            idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/srt_div_arbiter.sv
// Shares one SRTDivider among NREQ requesters with round-robin arbitration.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : srt_div_arbiter_if slave (request handshakes, operands, response)
// Only one operation is in flight: grant in IDLE, reset the divider for one
// cycle (CLEAR), run it until done, then hold the result until accepted.
module srt_div_arbiter
    import srt_div_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int NREQ = DEF_NREQ
) (
    input  logic            clk,
    input  logic            rst,
    srt_div_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    state_t          state_reg, state_next;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            handshake;

    // last_reg is both the round-robin pointer and the in-flight owner ID
    logic [IDW-1:0]  last_reg;
    logic [N-1:0]    x_reg, y_reg;
    logic            signed_reg;

    logic [IDW-1:0]  resp_id_reg;
    logic [N-1:0]    resp_q_reg, resp_r_reg;
    logic            resp_dbz_reg;

    logic            div_rst, div_start, div_done, div_dbz;
    logic [N-1:0]    div_q, div_r;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (bus.req_valid),
        .last  (last_reg),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_idx = IDW'(i);
        end
    end

    always_comb begin
        state_next    = state_reg;
        handshake     = 1'b0;
        bus.req_ready = '0;
        case (state_reg)
            IDLE: begin
                // grant is non-zero only when its requester is valid
                bus.req_ready = grant;
                if (|grant) begin
                    handshake  = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR:   state_next = RUN;
            RUN:     if (div_done) state_next = RESP;
            RESP:    if (bus.resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            last_reg     <= IDW'(NREQ - 1);
            x_reg        <= '0;
            y_reg        <= '0;
            signed_reg   <= 1'b0;
            resp_id_reg  <= '0;
            resp_q_reg   <= '0;
            resp_r_reg   <= '0;
            resp_dbz_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (handshake) begin
                x_reg      <= bus.req_x[grant_idx*N +: N];
                y_reg      <= bus.req_y[grant_idx*N +: N];
                signed_reg <= bus.req_signed[grant_idx];
                last_reg   <= grant_idx;
            end
            if (state_reg == RUN && div_done) begin
                resp_id_reg  <= last_reg;
                resp_q_reg   <= div_q;
                resp_r_reg   <= div_r;
                resp_dbz_reg <= div_dbz;
            end
        end
    end

    // divider restarts from a clean state for every operation
    assign div_rst   = rst | (state_reg == CLEAR);
    assign div_start = (state_reg == RUN);

    SRTDivider #(.N(N)) u_div (
        .clk         (clk),
        .rst         (div_rst),
        .start       (div_start),
        .x           (x_reg),
        .y           (y_reg),
        .signedInput (signed_reg),
        .done        (div_done),
        .q           (div_q),
        .r           (div_r),
        .divByZeroEx (div_dbz)
    );

    assign bus.resp_valid = (state_reg == RESP);
    assign bus.resp_id    = resp_id_reg;
    assign bus.resp_q     = resp_q_reg;
    assign bus.resp_r     = resp_r_reg;
    assign bus.resp_dbz   = resp_dbz_reg;

endmodule

// File: tb/tb_srt_div_arbiter.sv
`timescale 1ns/1ps
module tb_srt_div_arbiter;
    localparam int NA = 16, RA = 4;   // directed instance
    localparam int NB = 8,  RB = 3;   // random instance

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    srt_div_arbiter_if #(.N(NA), .NREQ(RA)) bus_a ();
    srt_div_arbiter_if #(.N(NB), .NREQ(RB)) bus_b ();

    srt_div_arbiter #(.N(NA), .NREQ(RA)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    srt_div_arbiter #(.N(NB), .NREQ(RB)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // model state per instance
    bit     busy_m [2];
    int     last_m [2];
    int     hs_m   [2];
    longint eq_m   [2];
    longint er_m   [2];
    int     eid_m  [2];
    bit     edbz_m [2];

    // hand-computed literal expectations for instance A, in response order
    int lit_id [16];
    int lit_q  [16];
    int lit_r  [16];
    int lit_dbz[16];
    int lit_wr = 0;        // written by directed stimulus only
    int lit_rd = 0;        // written by compare only
    int tmo_pending = 0;   // written by directed stimulus only
    int tmo_seen = 0;      // written by compare only
    bit final_req = 0;
    bit final_done = 0;
    bit done_b = 0;

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL inst%0d %s actual=%0h required=%0h t=%0t", k, nm, act, exp, $time);
        end
    endtask

    // quotient truncated toward zero; remainder is |x| mod |y|
    function automatic void div_model(input longint x, input longint y, input bit s, input int w,
                                      output longint q, output longint r, output bit dbz);
        longint sx, sy, ax, ay, mask;
        mask = (longint'(1) << w) - 1;
        sx = x; sy = y;
        if (s && ((x >> (w-1)) & 1) != 0) sx = x - (longint'(1) << w);
        if (s && ((y >> (w-1)) & 1) != 0) sy = y - (longint'(1) << w);
        ax = (sx < 0) ? -sx : sx;
        ay = (sy < 0) ? -sy : sy;
        dbz = (y == 0);
        q = 0; r = 0;
        if (!dbz) begin
            q = ax / ay;
            r = ax % ay;
            if ((sx < 0) != (sy < 0)) q = -q;
        end
        q = q & mask;
        r = r & mask;
    endfunction

    task automatic model_step(input int k, input int w, input int nreq,
                              input logic [7:0] valid, input logic [7:0] ready,
                              input logic [63:0] xs, input logic [63:0] ys, input logic [7:0] sg,
                              input logic rv, input int rid, input longint rq, input longint rr,
                              input logic rdbz, input logic rrdy);
        int win;
        longint mask, ex, ey, q, r;
        bit d;
        mask = (longint'(1) << w) - 1;
        if (rst) begin
            busy_m[k] = 0;
            last_m[k] = nreq - 1;
            chk("rst_resp_valid", k, 64'(rv), 64'd0);
            chk("rst_resp_id", k, 64'(rid), 64'd0);
            chk("rst_resp_q", k, 64'(rq), 64'd0);
            chk("rst_resp_r", k, 64'(rr), 64'd0);
            chk("rst_resp_dbz", k, 64'(rdbz), 64'd0);
        end else if (!busy_m[k]) begin
            win = -1;
            for (int i = 1; i <= nreq; i++) begin
                int j;
                j = (last_m[k] + i) % nreq;
                if (win < 0 && valid[j]) win = j;
            end
            chk("req_ready_idle", k, 64'(ready), (win < 0) ? 64'd0 : (64'd1 << win));
            chk("resp_valid_idle", k, 64'(rv), 64'd0);
            if (win >= 0) begin
                busy_m[k] = 1;
                last_m[k] = win;
                hs_m[k]   = cyc + 1;
                ex = longint'(xs >> (win * w)) & mask;
                ey = longint'(ys >> (win * w)) & mask;
                div_model(ex, ey, sg[win], w, q, r, d);
                eq_m[k] = q; er_m[k] = r; edbz_m[k] = d; eid_m[k] = win;
            end
        end else begin
            chk("req_ready_busy", k, 64'(ready), 64'd0);
            // handshake edge + CLEAR + divider (N+1) + RESP register
            if (cyc >= hs_m[k] + w + 3) begin
                chk("resp_valid", k, 64'(rv), 64'd1);
                chk("resp_id", k, 64'(rid), 64'(eid_m[k]));
                chk("resp_dbz", k, 64'(rdbz), 64'(edbz_m[k]));
                if (!edbz_m[k]) begin
                    chk("resp_q", k, 64'(rq), 64'(eq_m[k]));
                    chk("resp_r", k, 64'(rr), 64'(er_m[k]));
                end
                if (rrdy) begin
                    busy_m[k] = 0;
                    if (k == 0) begin
                        if (lit_rd < lit_wr) begin
                            chk("lit_id", k, 64'(rid), 64'(lit_id[lit_rd]));
                            chk("lit_dbz", k, 64'(rdbz), 64'(lit_dbz[lit_rd]));
                            if (lit_dbz[lit_rd] == 0) begin
                                chk("lit_q", k, 64'(rq), 64'(lit_q[lit_rd]));
                                chk("lit_r", k, 64'(rr), 64'(lit_r[lit_rd]));
                            end
                            lit_rd++;
                        end else begin
                            chk("lit_resp_count", k, 64'(lit_rd + 1), 64'(lit_wr));
                        end
                    end
                end
            end else begin
                chk("resp_valid_early", k, 64'(rv), 64'd0);
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0, NA, RA, 8'(bus_a.req_valid), 8'(bus_a.req_ready), 64'(bus_a.req_x),
                   64'(bus_a.req_y), 8'(bus_a.req_signed), bus_a.resp_valid, int'(bus_a.resp_id),
                   longint'(bus_a.resp_q), longint'(bus_a.resp_r), bus_a.resp_dbz, bus_a.resp_ready);
        model_step(1, NB, RB, 8'(bus_b.req_valid), 8'(bus_b.req_ready), 64'(bus_b.req_x),
                   64'(bus_b.req_y), 8'(bus_b.req_signed), bus_b.resp_valid, int'(bus_b.resp_id),
                   longint'(bus_b.resp_q), longint'(bus_b.resp_r), bus_b.resp_dbz, bus_b.resp_ready);
        if (tmo_pending != tmo_seen) begin
            chk("wait_timeout", 0, 64'(tmo_pending), 64'(tmo_seen));
            tmo_seen = tmo_pending;
        end
        if (final_req && !final_done) begin
            chk("lit_all_consumed", 0, 64'(lit_rd), 64'(lit_wr));
            final_done = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_lit(input int id, input int q, input int r, input int dbz);
        lit_id[lit_wr] = id; lit_q[lit_wr] = q; lit_r[lit_wr] = r; lit_dbz[lit_wr] = dbz;
        lit_wr++;
    endtask

    task automatic set_req(input int k, input logic [15:0] x, input logic [15:0] y, input logic s);
        bus_a.req_x[k*NA +: NA] = x;
        bus_a.req_y[k*NA +: NA] = y;
        bus_a.req_signed[k]     = s;
        bus_a.req_valid[k]      = 1'b1;
    endtask

    task automatic wait_grant(input int k);
        int n;
        n = 0;
        #1;
        while (!bus_a.req_ready[k] && n < 100) begin tick(); n++; end
        if (n >= 100) tmo_pending++;
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (!(bus_a.resp_valid && bus_a.resp_ready) && n < 200) begin tick(); n++; end
        if (n >= 200) tmo_pending++;
        tick();
    endtask

    // directed instance
    initial begin
        int n, guard;
        rst = 1'b1;
        bus_a.req_valid = '0; bus_a.req_signed = '0; bus_a.req_x = '0; bus_a.req_y = '0;
        bus_a.resp_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // unsigned 100/7; operands scrambled after handshake
        push_lit(0, 14, 2, 0);
        set_req(0, 16'd100, 16'd7, 1'b0);
        wait_grant(0); tick();
        bus_a.req_valid[0] = 1'b0; bus_a.req_x[0 +: NA] = 16'h1234; bus_a.req_y[0 +: NA] = 16'h0;
        wait_resp();

        // signed -100/7
        push_lit(1, 16'hFFF2, 16'h0002, 0);
        set_req(1, 16'hFF9C, 16'd7, 1'b1);
        wait_grant(1); tick();
        bus_a.req_valid[1] = 1'b0;
        wait_resp();

        // fairness: req0 and req2 valid continuously from reset
        rst = 1'b1;
        set_req(0, 16'd50, 16'd5, 1'b0);
        set_req(2, 16'd9, 16'd4, 1'b0);
        tick();
        rst = 1'b0;
        push_lit(0, 10, 0, 0); push_lit(2, 2, 1, 0);
        push_lit(0, 10, 0, 0); push_lit(2, 2, 1, 0);
        n = 0; guard = 0;
        while (n < 4 && guard < 400) begin
            if (bus_a.resp_valid) begin
                n++;
                if (n == 4) bus_a.req_valid = '0;
            end
            tick(); guard++;
        end
        if (guard >= 400) tmo_pending++;
        tick();

        // divide-by-zero from req3 under backpressure; req1 waits behind it
        bus_a.resp_ready = 1'b0;
        push_lit(3, 0, 0, 1);
        push_lit(1, 5, 1, 0);
        set_req(3, 16'd5, 16'd0, 1'b0);
        set_req(1, 16'd21, 16'd4, 1'b0);
        wait_grant(3); tick();
        bus_a.req_valid[3] = 1'b0;
        n = 0;
        while (!bus_a.resp_valid && n < 200) begin tick(); n++; end
        if (n >= 200) tmo_pending++;
        repeat (3) tick();
        bus_a.resp_ready = 1'b1;
        wait_grant(1); tick();
        bus_a.req_valid[1] = 1'b0;
        wait_resp();

        // reset in RUN drops the op; next request granted in first IDLE cycle
        set_req(2, 16'd1000, 16'd3, 1'b0);
        wait_grant(2); tick();
        bus_a.req_valid[2] = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        push_lit(0, 16'hFFFF, 0, 0);
        set_req(0, 16'hFFFF, 16'd1, 1'b0);
        tick();
        rst = 1'b0;
        wait_grant(0); tick();
        bus_a.req_valid[0] = 1'b0;
        wait_resp();

        guard = 0;
        while (!done_b && guard < 20000) begin tick(); guard++; end
        repeat (30) tick();
        final_req = 1;
        guard = 0;
        while (!final_done && guard < 10) begin tick(); guard++; end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // random instance: random requesters, operands, signedness and resp_ready
    initial begin
        bus_b.req_valid = '0; bus_b.req_signed = '0; bus_b.req_x = '0; bus_b.req_y = '0;
        bus_b.resp_ready = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            bus_b.req_valid  = RB'($urandom_range(0, 7));
            bus_b.req_signed = RB'($urandom_range(0, 7));
            for (int k = 0; k < RB; k++) begin
                bus_b.req_x[k*NB +: NB] = NB'($urandom);
                bus_b.req_y[k*NB +: NB] = ($urandom_range(0, 7) == 0) ? '0 : NB'($urandom);
            end
            bus_b.resp_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        bus_b.req_valid  = '0;
        bus_b.resp_ready = 1'b1;
        done_b = 1;
    end

endmodule
